// File: rtl/uart_ser_param.sv
// Parametrised parallel-to-serial shifter for the UART TX path, with a busy handshake and a one-cycle ser_done pulse.
// Optional parity bit after the data word when UART_SER_PARITY_EN is defined (adds par_en/par_odd ports).
module uart_ser_param #(
  parameter int   DATA_W     = 8,
  parameter bit   LSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            data_valid,
  input  logic [DATA_W-1:0]               p_data,
`ifdef UART_SER_PARITY_EN
  input  logic                            par_en,
  input  logic                            par_odd,
`endif
  input  logic                            ser_en,
  output logic                            busy,
  output logic                            ser_data,
  output logic                            ser_done,
  output logic [$clog2(DATA_W+1)-1:0]     bit_cnt
);

  localparam int CW = $clog2(DATA_W+1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef UART_SER_PARITY_EN
  localparam logic [1:0] S_PAR   = 2'd2;
`endif

  logic [1:0]        state;
  logic [DATA_W-1:0] sreg;
  logic              next_bit;
  logic              last_data;
`ifdef UART_SER_PARITY_EN
  logic              par_bit;
  logic              par_pend;
`endif

  assign next_bit  = LSB_FIRST ? sreg[0] : sreg[DATA_W-1];
  assign last_data = (bit_cnt == CW'(DATA_W-1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      sreg     <= '0;
      busy     <= 1'b0;
      ser_data <= IDLE_LEVEL;
      ser_done <= 1'b0;
      bit_cnt  <= '0;
`ifdef UART_SER_PARITY_EN
      par_bit  <= 1'b0;
      par_pend <= 1'b0;
`endif
    end else begin
      ser_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // bit_cnt keeps DATA_W after a finished word until the next capture
          ser_data <= IDLE_LEVEL;
          if (data_valid) begin
            sreg    <= p_data;
            busy    <= 1'b1;
            bit_cnt <= '0;
            state   <= S_SHIFT;
`ifdef UART_SER_PARITY_EN
            par_bit  <= (^p_data) ^ par_odd;
            par_pend <= par_en;
`endif
          end
        end
        S_SHIFT: begin
          if (ser_en) begin
            ser_data <= next_bit;
            sreg     <= LSB_FIRST ? (sreg >> 1) : (sreg << 1);
            bit_cnt  <= bit_cnt + 1'b1;
            if (last_data) begin
`ifdef UART_SER_PARITY_EN
              if (par_pend) state <= S_PAR;
              else
`endif
              begin
                ser_done <= 1'b1;
                busy     <= 1'b0;
                state    <= S_IDLE;
              end
            end
          end
        end
`ifdef UART_SER_PARITY_EN
        S_PAR: begin
          // bit_cnt stays at DATA_W through the parity bit
          if (ser_en) begin
            ser_data <= par_bit;
            ser_done <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ser_param.sv
// Scoreboard bench for uart_ser_param: 8-bit LSB-first, 8-bit MSB-first and 12-bit LSB-first instances.
// Parity scenarios run only when UART_SER_PARITY_EN is defined.
module tb_uart_ser_param;

  localparam int N = 3;

  typedef struct packed {
    logic       d;
    logic       dn;
    logic [3:0] c;
  } item_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        ser_en = 1'b0;
  logic [15:0] p_data = '0;
  logic [2:0]  dv = '0;
`ifdef UART_SER_PARITY_EN
  logic        par_en = 1'b0;
  logic        par_odd = 1'b0;
`endif

  logic        busy_w [N];
  logic        ser_w  [N];
  logic        done_w [N];
  logic [3:0]  cnt_w  [N];

  int    total = 0;
  int    bad = 0;
  item_t exp_q [N][$];
  int    width_n [N] = '{8, 8, 12};
  bit    lsb_n   [N] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  uart_ser_param #(.DATA_W(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u0 (
    .clk(clk), .rstn(rstn), .data_valid(dv[0]), .p_data(p_data[7:0]),
`ifdef UART_SER_PARITY_EN
    .par_en(par_en), .par_odd(par_odd),
`endif
    .ser_en(ser_en), .busy(busy_w[0]), .ser_data(ser_w[0]),
    .ser_done(done_w[0]), .bit_cnt(cnt_w[0])
  );

  uart_ser_param #(.DATA_W(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u1 (
    .clk(clk), .rstn(rstn), .data_valid(dv[1]), .p_data(p_data[7:0]),
`ifdef UART_SER_PARITY_EN
    .par_en(par_en), .par_odd(par_odd),
`endif
    .ser_en(ser_en), .busy(busy_w[1]), .ser_data(ser_w[1]),
    .ser_done(done_w[1]), .bit_cnt(cnt_w[1])
  );

  uart_ser_param #(.DATA_W(12), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u2 (
    .clk(clk), .rstn(rstn), .data_valid(dv[2]), .p_data(p_data[11:0]),
`ifdef UART_SER_PARITY_EN
    .par_en(par_en), .par_odd(par_odd),
`endif
    .ser_en(ser_en), .busy(busy_w[2]), .ser_data(ser_w[2]),
    .ser_done(done_w[2]), .bit_cnt(cnt_w[2])
  );

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, req, $time);
    end
  endtask

  // Expected serial stream for each selected instance, parity bit last when requested
  task automatic push_word(input logic [2:0] mask, input logic [15:0] w, input bit pe, input bit po);
    item_t it;
    int    n;
    logic  p;
    for (int k = 0; k < N; k++) begin
      if (mask[k]) begin
        n = width_n[k];
        p = po;
        for (int i = 0; i < n; i++) begin
          it.d  = lsb_n[k] ? w[i] : w[n-1-i];
          it.c  = 4'(i + 1);
          it.dn = (i == n - 1) && !pe;
          p     = p ^ w[i];
          exp_q[k].push_back(it);
        end
        if (pe) begin
          it.d  = p;
          it.c  = 4'(n);
          it.dn = 1'b1;
          exp_q[k].push_back(it);
        end
      end
    end
  endtask

  task automatic load(input logic [2:0] mask, input logic [15:0] w, input bit pe, input bit po, input bit push);
    p_data = w;
    dv     = mask;
`ifdef UART_SER_PARITY_EN
    par_en  = pe;
    par_odd = po;
`endif
    if (push) push_word(mask, w, pe, po);
    $display("load mask=%b word=%h par_en=%0d par_odd=%0d expect=%0d", mask, w, pe, po, push);
    @(posedge clk); #1;
    dv = '0;
  endtask

  task automatic shift(input int n);
    ser_en = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    ser_en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_vals(input int kmax);
    for (int k = 0; k < kmax; k++) begin
      chk("rst_busy", k, 32'(busy_w[k]), 32'd0);
      chk("rst_ser_data", k, 32'(ser_w[k]), 32'd1);
      chk("rst_ser_done", k, 32'(done_w[k]), 32'd0);
      chk("rst_bit_cnt", k, 32'(cnt_w[k]), 32'd0);
    end
  endtask

  // Monitor: a bit is due after every edge that saw busy=1 and ser_en=1
  logic       prev_busy [N];
  logic       prev_en;
  logic       last_d [N];
  logic [3:0] last_c [N];

  initial begin
    item_t it;
    prev_en = 1'b0;
    for (int k = 0; k < N; k++) begin
      prev_busy[k] = 1'b0;
      last_d[k]    = 1'b1;
      last_c[k]    = '0;
    end
    forever begin
      @(negedge clk);
      if (!rstn) begin
        for (int k = 0; k < N; k++) prev_busy[k] = 1'b0;
        prev_en = 1'b0;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (prev_busy[k] && prev_en) begin
            if (exp_q[k].size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_bit inst%0d: got ser_data=%0b with no expected bit at %0t", k, ser_w[k], $time);
            end else begin
              it = exp_q[k].pop_front();
              chk("ser_data", k, 32'(ser_w[k]), 32'(it.d));
              chk("ser_done", k, 32'(done_w[k]), 32'(it.dn));
              chk("bit_cnt", k, 32'(cnt_w[k]), 32'(it.c));
              chk("busy", k, 32'(busy_w[k]), 32'(!it.dn));
              $display("bit inst%0d data=%0b done=%0b cnt=%0d", k, ser_w[k], done_w[k], cnt_w[k]);
              last_d[k] = it.d;
              last_c[k] = it.c;
            end
          end else if (prev_busy[k]) begin
            chk("stall_ser_data", k, 32'(ser_w[k]), 32'(last_d[k]));
            chk("stall_bit_cnt", k, 32'(cnt_w[k]), 32'(last_c[k]));
            chk("stall_ser_done", k, 32'(done_w[k]), 32'd0);
          end else begin
            chk("idle_ser_data", k, 32'(ser_w[k]), 32'd1);
            chk("idle_ser_done", k, 32'(done_w[k]), 32'd0);
            if (busy_w[k]) begin
              chk("capture_bit_cnt", k, 32'(cnt_w[k]), 32'd0);
              last_d[k] = 1'b1;
              last_c[k] = '0;
            end
          end
          prev_busy[k] = busy_w[k];
        end
        prev_en = ser_en;
      end
    end
  end

  initial begin
    #2 rstn = 1'b0;
    #10;
    check_reset_vals(N);
    @(posedge clk); #1 rstn = 1'b1;
    idle(2);

    // Full word with ser_en already high at capture: capture edge emits nothing
    ser_en = 1'b1;
    load(3'b011, 16'h00B4, 1'b0, 1'b0, 1'b1);
    shift(8);
    idle(2);

    // Stalls: each bit holds, bit_cnt frozen
    load(3'b011, 16'h00B4, 1'b0, 1'b0, 1'b1);
    begin
      bit pat [12] = '{1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 1, 1};
      for (int i = 0; i < 12; i++) begin
        ser_en = pat[i];
        @(posedge clk); #1;
      end
    end
    idle(2);

    // data_valid while busy is ignored
    load(3'b011, 16'h00B4, 1'b0, 1'b0, 1'b1);
    shift(3);
    load(3'b011, 16'h003C, 1'b0, 1'b0, 1'b0);
    shift(4);
    idle(2);

    // Back-to-back: next word accepted in the ser_done cycle
    load(3'b011, 16'h00B4, 1'b0, 1'b0, 1'b1);
    shift(8);
    load(3'b011, 16'h005A, 1'b0, 1'b0, 1'b1);
    shift(8);
    idle(2);

    // Reset mid-word after the 3rd bit
    load(3'b011, 16'h00B4, 1'b0, 1'b0, 1'b1);
    shift(3);
    #1 rstn = 1'b0;
    #1;
    check_reset_vals(2);
    for (int k = 0; k < N; k++) exp_q[k].delete();
    @(posedge clk); #1 rstn = 1'b1;
    load(3'b011, 16'h00FF, 1'b0, 1'b0, 1'b1);
    shift(8);
    idle(2);

    // 12-bit instance alongside the 8-bit ones (which see 0x01)
    load(3'b111, 16'h0F01, 1'b0, 1'b0, 1'b1);
    shift(12);
    idle(2);

`ifdef UART_SER_PARITY_EN
    load(3'b011, 16'h00B4, 1'b1, 1'b0, 1'b1);
    shift(9);
    idle(2);
    load(3'b011, 16'h00B4, 1'b1, 1'b1, 1'b1);
    ser_en = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    idle(2);
    shift(1);
    idle(2);
    load(3'b011, 16'h00B4, 1'b0, 1'b0, 1'b1);
    shift(8);
    idle(2);
    load(3'b100, 16'h0F01, 1'b1, 1'b0, 1'b1);
    shift(13);
    idle(2);
`endif

    idle(3);
    for (int k = 0; k < N; k++) chk("queue_drained", k, 32'(exp_q[k].size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
